// File: rtl/instr_encoder.sv
// Instruction encoder: packs RISC-V style field sets (R/I/S/SB/U/UJ) into a
// 32-bit word with one cycle of latency, tracks an internal PC for the
// PC-relative formats, and keeps a saturating count of erroneous words.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // True when imm[31:12] is the sign extension of imm[11].
  function automatic logic imm12_fits(input logic [31:0] v);
    return (&v[31:11]) || !(|v[31:11]);
  endfunction

  // Increment a count, holding at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [31:0]        r_pc;
  logic               r_vld_p1;
  logic [31:0]        r_instr_p1;
  logic [31:0]        r_pc_p1;
  logic               r_err_p1;
  logic [7:0]         r_err_cnt;

  logic               w_accept;
  logic [31:0]        w_pc_p0;
  logic signed [31:0] w_off_p0;
  logic [31:0]        w_instr_p0;
  logic               w_err_p0;

  assign in_ready  = !r_vld_p1 || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A simultaneous PC load takes effect for the word being accepted.
  assign w_pc_p0   = pc_load ? pc_load_val : r_pc;
  assign w_off_p0  = $signed(imm - w_pc_p0);

  // Stage p0: combinational packing of the presented field set.
  always_comb begin
    w_instr_p0 = NOP_WORD;
    w_err_p0   = 1'b1;
    case (fmt)
      3'd0: begin
        w_instr_p0 = {funct7, rs2, rs1, funct3, rd, opcode};
        w_err_p0   = 1'b0;
      end
      3'd1: begin
        w_instr_p0 = {imm[11:0], rs1, funct3, rd, opcode};
        w_err_p0   = !imm12_fits(imm);
      end
      3'd2: begin
        w_instr_p0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_err_p0   = !imm12_fits(imm);
      end
      3'd3: begin
        w_instr_p0 = {w_off_p0[12], w_off_p0[10:5], rs2, rs1, funct3,
                      w_off_p0[4:1], w_off_p0[11], opcode};
        w_err_p0   = w_off_p0[0] || (w_off_p0 < -32'sd4096) ||
                     (w_off_p0 > 32'sd4094);
      end
      3'd4: begin
        w_instr_p0 = {imm[31:12], rd, opcode};
        w_err_p0   = |imm[11:0];
      end
      3'd5: begin
        w_instr_p0 = {w_off_p0[20], w_off_p0[10:1], w_off_p0[11],
                      w_off_p0[19:12], rd, opcode};
        w_err_p0   = w_off_p0[0] || (w_off_p0 < -32'sd1048576) ||
                     (w_off_p0 > 32'sd1048574);
      end
      default: begin
        w_instr_p0 = NOP_WORD;
        w_err_p0   = 1'b1;
      end
    endcase
  end

  // Stage p1: output register, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_instr_p1 <= '0;
      r_pc_p1    <= '0;
      r_err_p1   <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1   <= 1'b1;
      r_instr_p1 <= w_instr_p0;
      r_pc_p1    <= w_pc_p0;
      r_err_p1   <= w_err_p0;
    end else if (out_ready) begin
      r_vld_p1   <= 1'b0;
    end
  end

  // Internal PC: advances past each accepted word, or takes a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (w_accept) begin
      r_pc <= w_pc_p0 + 32'd4;
    end else if (pc_load) begin
      r_pc <= pc_load_val;
    end
  end

  // Error counter: one step per accepted erroneous word, never on a hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err_p0) begin
      r_err_cnt <= sat_inc8(r_err_cnt);
    end
  end

  assign out_valid = r_vld_p1;
  assign out_instr = r_instr_p1;
  assign out_pc    = r_pc_p1;
  assign out_err   = r_err_p1;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    pc_load = 1'b0; pc_load_val = '0;
    drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cyc(); cyc();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_cnt", {24'd0, err_cnt}, 32'd0);

    // addi x1, x0, 5 at PC 0
    rst = 1'b0; in_valid = 1'b1;
    drive(3'd1, 7'h13, 3'd0, 7'h55, 5'd1, 5'd0, 5'd31, 32'd5);
    cyc();
    chk("i_instr", out_instr, 32'h00500093);
    chk("i_pc", out_pc, 32'd0);
    chk("i_err", {31'd0, out_err}, 32'd0);
    chk("i_valid", {31'd0, out_valid}, 32'd1);

    // sub x1, x2, x3
    drive(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEADBEEF);
    cyc();
    chk("r_instr", out_instr, 32'h403100B3);
    chk("r_pc", out_pc, 32'd4);

    // sw x5, -4(x2)
    drive(3'd2, 7'h23, 3'd2, 7'h00, 5'd9, 5'd2, 5'd5, 32'hFFFFFFFC);
    cyc();
    chk("s_instr", out_instr, 32'hFE512E23);
    chk("s_pc", out_pc, 32'd8);
    chk("s_err", {31'd0, out_err}, 32'd0);

    // I with immediate not representable in 12 bits
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000800);
    cyc();
    chk("ierr_instr", out_instr, 32'h80000013);
    chk("ierr_err", {31'd0, out_err}, 32'd1);
    chk("ierr_cnt", {24'd0, err_cnt}, 32'd1);

    // lui x5, 0x12345 then the same with nonzero low bits
    drive(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
    cyc();
    chk("u_instr", out_instr, 32'h123452B7);
    chk("u_err", {31'd0, out_err}, 32'd0);
    chk("u_pc", out_pc, 32'd16);
    drive(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001);
    cyc();
    chk("uerr_instr", out_instr, 32'h123452B7);
    chk("uerr_err", {31'd0, out_err}, 32'd1);
    chk("uerr_cnt", {24'd0, err_cnt}, 32'd2);

    // illegal format
    drive(3'd7, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF);
    cyc();
    chk("ill_instr", out_instr, 32'h00000013);
    chk("ill_err", {31'd0, out_err}, 32'd1);
    chk("ill_cnt", {24'd0, err_cnt}, 32'd3);

    // SB offset +4096 from PC 28: one past the range, truncated bits kept
    drive(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000101C);
    cyc();
    chk("sbrng_pc", out_pc, 32'd28);
    chk("sbrng_instr", out_instr, 32'h80000063);
    chk("sbrng_err", {31'd0, out_err}, 32'd1);
    chk("sbrng_cnt", {24'd0, err_cnt}, 32'd4);

    // beq x1, x2, -8 with PC loaded to 0x100 in the same cycle
    pc_load = 1'b1; pc_load_val = 32'h100;
    drive(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h000000F8);
    cyc();
    chk("sb_instr", out_instr, 32'hFE208CE3);
    chk("sb_pc", out_pc, 32'h100);
    chk("sb_err", {31'd0, out_err}, 32'd0);
    pc_load = 1'b0;
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    cyc();
    chk("after_load_pc", out_pc, 32'h104);

    // jal x1, -2048 from PC 0x1000
    pc_load = 1'b1; pc_load_val = 32'h1000;
    drive(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800);
    cyc();
    pc_load = 1'b0;
    chk("uj_instr", out_instr, 32'h801FF0EF);
    chk("uj_pc", out_pc, 32'h1000);
    chk("uj_err", {31'd0, out_err}, 32'd0);

    // downstream stall for 3 cycles with new illegal words waiting
    out_ready = 1'b0;
    drive(3'd7, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_instr", out_instr, 32'h801FF0EF);
      chk("stall_pc", out_pc, 32'h1000);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_cnt", {24'd0, err_cnt}, 32'd4);
    end
    out_ready = 1'b1;
    cyc();
    chk("rel_pc0", out_pc, 32'h1004);
    chk("rel_cnt0", {24'd0, err_cnt}, 32'd5);
    cyc();
    chk("rel_pc1", out_pc, 32'h1008);
    chk("rel_cnt1", {24'd0, err_cnt}, 32'd6);
    in_valid = 1'b0;
    cyc();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // reset while a word is held
    in_valid = 1'b1; out_ready = 1'b0;
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    cyc();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_cnt", {24'd0, err_cnt}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    rst = 1'b0; out_ready = 1'b1;
    cyc();
    chk("post_rst_pc", out_pc, 32'd0);
    chk("post_rst_instr", out_instr, 32'h00500093);

    // misaligned jal from PC 0, then saturation of the error count
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000003);
    cyc();
    chk("ujerr_instr", out_instr, 32'h0020006F);
    chk("ujerr_err", {31'd0, out_err}, 32'd1);
    chk("ujerr_pc", out_pc, 32'd0);
    chk("ujerr_cnt", {24'd0, err_cnt}, 32'd1);
    drive(3'd6, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 253; i++) cyc();
    chk("cnt_254", {24'd0, err_cnt}, 32'd254);
    for (int i = 0; i < 47; i++) cyc();
    chk("cnt_sat", {24'd0, err_cnt}, 32'd255);
    chk("ill6_instr", out_instr, 32'h00000013);
    in_valid = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
